voice_scheduler: RTL and testbench



---
 rtl/music_pkg.sv | 20 ++
 rtl/sample_mixer.sv | 95 +++++++++
 rtl/voice_scheduler.sv | 119 +++++++++++
 tb/tb_voice_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared widths, mixer state encoding and sample saturation for the voice scheduler.
package music_pkg;
    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 19;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;
    localparam logic signed [ACC_W-1:0]    ACC_MAX    = 19'sd32767;
    localparam logic signed [ACC_W-1:0]    ACC_MIN    = -19'sd32768;

    typedef enum logic [1:0] {IDLE, WAIT, SUM, OUT} mix_state_e;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        if (acc > ACC_MAX)      return SAMPLE_MAX;
        else if (acc < ACC_MIN) return SAMPLE_MIN;
        else                    return acc[SAMPLE_W-1:0];
    endfunction
endpackage

// File: rtl/sample_mixer.sv
// Per-sample collection FSM: waits for the active voices' samples (or a timeout),
// then emits one saturated sum.
module sample_mixer
    import music_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            generate_next_sample,
    input  logic [NUM_VOICES-1:0]           voice_active,
    input  logic [SAMPLE_W*NUM_VOICES-1:0]  voice_samples,
    input  logic [NUM_VOICES-1:0]           voice_sample_ready,
    output logic signed [SAMPLE_W-1:0]      sample_out,
    output logic                            new_sample_ready
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mix_state_e                           state_q, state_d;
    logic [NUM_VOICES-1:0]                need_q, need_d;
    logic [NUM_VOICES-1:0]                got_q, got_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  latch_q, latch_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0]           sample_q, sample_d;
    logic                                 nsr_q, nsr_d;
    logic signed [ACC_W-1:0]              acc;

    // Missing voices were never marked in got_q, so they drop out of the sum.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (need_q[i] && got_q[i]) acc = acc + ACC_W'(signed'(latch_q[i]));
        end
    end

    always_comb begin
        state_d  = state_q;
        need_d   = need_q;
        got_d    = got_q;
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        nsr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (generate_next_sample) begin
                    need_d  = voice_active;
                    got_d   = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                got_d = got_q | voice_sample_ready;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (voice_sample_ready[i]) latch_d[i] = voice_samples[SAMPLE_W*i +: SAMPLE_W];
                end
                if (((got_d & need_q) == need_q) || (cnt_q == CNT_W'(TIMEOUT))) state_d = SUM;
                else cnt_d = cnt_q + 1'b1;
            end
            // Result is registered here so it is already valid during OUT.
            SUM: begin
                sample_d = saturate(acc);
                nsr_d    = 1'b1;
                state_d  = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            need_q   <= '0;
            got_q    <= '0;
            latch_q  <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            nsr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            need_q   <= need_d;
            got_q    <= got_d;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            nsr_q    <= nsr_d;
        end
    end

    assign sample_out       = sample_q;
    assign new_sample_ready = nsr_q;
endmodule

// File: rtl/voice_scheduler.sv
// Voice allocation with stealing, per-voice beat countdown, and the sample mixer.
module voice_scheduler
    import music_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic                            beat,
    input  logic                            load_new_note,
    input  logic [NOTE_W-1:0]               note,
    input  logic [DUR_W-1:0]                duration,
    input  logic                            generate_next_sample,
    input  logic [SAMPLE_W*NUM_VOICES-1:0]  voice_samples,
    input  logic [NUM_VOICES-1:0]           voice_sample_ready,
    output logic [NUM_VOICES-1:0]           voice_load,
    output logic [NOTE_W-1:0]               voice_note,
    output logic [DUR_W-1:0]                voice_duration,
    output logic [NUM_VOICES-1:0]           voice_active,
    output logic signed [SAMPLE_W-1:0]      sample_out,
    output logic                            new_sample_ready
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0][DUR_W-1:0] remaining_q, remaining_d;
    logic [NUM_VOICES-1:0]            voice_load_q, voice_load_d;
    logic [NOTE_W-1:0]                voice_note_q, voice_note_d;
    logic [DUR_W-1:0]                 voice_duration_q, voice_duration_d;
    logic [NUM_VOICES-1:0]            active;
    logic [NUM_VOICES-1:0]            sel_oh;
    logic [IDX_W-1:0]                 free_idx, steal_idx, sel_idx;
    logic [DUR_W-1:0]                 min_rem;
    logic                             any_free;
    logic                             load_ok;

    // A voice is active exactly while it has beats left.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) active[i] = (remaining_q[i] != '0);
    end

    assign load_ok = load_new_note && (note != '0) && (duration != '0);

    // Strict '<' keeps the lowest index on ties.
    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        steal_idx = '0;
        min_rem   = remaining_q[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (remaining_q[i] < min_rem) begin
                min_rem   = remaining_q[i];
                steal_idx = IDX_W'(i);
            end
        end
    end

    assign sel_idx = any_free ? free_idx : steal_idx;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) sel_oh[i] = load_ok && (sel_idx == IDX_W'(i));
    end

    // The freshly loaded voice takes the new duration and skips this cycle's beat.
    always_comb begin
        remaining_d      = remaining_q;
        voice_load_d     = sel_oh;
        voice_note_d     = voice_note_q;
        voice_duration_d = voice_duration_q;
        if (load_ok) begin
            voice_note_d     = note;
            voice_duration_d = duration;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (sel_oh[i])                      remaining_d[i] = duration;
            else if (beat && play && active[i]) remaining_d[i] = remaining_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q      <= '0;
            voice_load_q     <= '0;
            voice_note_q     <= '0;
            voice_duration_q <= '0;
        end else begin
            remaining_q      <= remaining_d;
            voice_load_q     <= voice_load_d;
            voice_note_q     <= voice_note_d;
            voice_duration_q <= voice_duration_d;
        end
    end

    sample_mixer #(
        .NUM_VOICES (NUM_VOICES),
        .TIMEOUT    (TIMEOUT)
    ) u_mixer (
        .clk                  (clk),
        .reset                (reset),
        .generate_next_sample (generate_next_sample),
        .voice_active         (active),
        .voice_samples        (voice_samples),
        .voice_sample_ready   (voice_sample_ready),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    assign voice_load     = voice_load_q;
    assign voice_note     = voice_note_q;
    assign voice_duration = voice_duration_q;
    assign voice_active   = active;
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed and random stimulus against a beat/voice/sample reference model.
module tb_voice_scheduler;
    localparam int NV = 3;
    localparam int TO = 255;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 play, beat, load_new_note, generate_next_sample;
    logic [5:0]           note, duration;
    logic [16*NV-1:0]     voice_samples;
    logic [NV-1:0]        voice_sample_ready;
    logic [NV-1:0]        voice_load, voice_active;
    logic [5:0]           voice_note, voice_duration;
    logic signed [15:0]   sample_out;
    logic                 new_sample_ready;

    int n_checks = 0;
    int n_errors = 0;

    voice_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .load_new_note(load_new_note), .note(note), .duration(duration),
        .generate_next_sample(generate_next_sample),
        .voice_samples(voice_samples), .voice_sample_ready(voice_sample_ready),
        .voice_load(voice_load), .voice_note(voice_note), .voice_duration(voice_duration),
        .voice_active(voice_active), .sample_out(sample_out),
        .new_sample_ready(new_sample_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: beats left per voice, and one pending sample request.
    int                 rem[NV];
    logic [NV-1:0]      m_load;
    logic [5:0]         m_note, m_dur;
    int                 m_mode;     // 0 idle, 1 collecting, 2 result pending
    logic [NV-1:0]      m_need, m_got;
    int                 m_samp[NV];
    int                 m_start, m_pulse, cyc;
    logic signed [15:0] m_pend, m_out;
    logic               m_nsr;

    function automatic logic [NV-1:0] m_active();
        logic [NV-1:0] a;
        for (int i = 0; i < NV; i++) a[i] = (rem[i] != 0);
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin rem[i] = 0; m_samp[i] = 0; end
        m_load = '0; m_note = '0; m_dur = '0;
        m_mode = 0; m_need = '0; m_got = '0;
        m_out = '0; m_nsr = 1'b0; m_pend = '0;
    endtask

    task automatic model_edge();
        logic [NV-1:0] act;
        int sel, s;
        act = m_active();
        sel = -1;
        if (load_new_note && note != 0 && duration != 0) begin
            for (int i = NV - 1; i >= 0; i--) if (rem[i] == 0) sel = i;
            if (sel < 0) begin
                sel = 0;
                for (int i = 1; i < NV; i++) if (rem[i] < rem[sel]) sel = i;
            end
        end
        m_load = '0;
        if (sel >= 0) begin m_load[sel] = 1'b1; m_note = note; m_dur = duration; end
        if (beat && play)
            for (int i = 0; i < NV; i++) if (i != sel && rem[i] > 0) rem[i]--;
        if (sel >= 0) rem[sel] = int'(duration);

        m_nsr = 1'b0;
        if (m_mode == 0) begin
            if (generate_next_sample) begin
                m_mode = 1; m_need = act; m_got = '0; m_start = cyc + 1;
            end
        end else if (m_mode == 1) begin
            for (int i = 0; i < NV; i++) begin
                if (voice_sample_ready[i]) begin
                    m_got[i] = 1'b1;
                    m_samp[i] = int'($signed(voice_samples[16*i +: 16]));
                end
            end
            if (((m_got & m_need) == m_need) || (cyc - m_start == TO)) begin
                s = 0;
                for (int i = 0; i < NV; i++) if (m_need[i] && m_got[i]) s += m_samp[i];
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                m_pend = 16'(s);
                m_pulse = cyc + 2;
                m_mode = 2;
            end
        end else begin
            if (cyc + 1 == m_pulse) begin m_nsr = 1'b1; m_out = m_pend; end
            if (cyc == m_pulse) m_mode = 0;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        check("voice_load", 32'(voice_load), 32'(m_load));
        check("voice_note", 32'(voice_note), 32'(m_note));
        check("voice_duration", 32'(voice_duration), 32'(m_dur));
        check("voice_active", 32'(voice_active), 32'(m_active()));
        check("new_sample_ready", 32'(new_sample_ready), 32'(m_nsr));
        check("sample_out", 32'(sample_out), 32'(m_out));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [5:0] n, input logic [5:0] d);
        load_new_note = 1'b1; note = n; duration = d;
        step();
        load_new_note = 1'b0;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_active", 32'(voice_active), 32'(0));
        check("arst_nsr", 32'(new_sample_ready), 32'(0));
        check("arst_sample", 32'(sample_out), 32'(0));
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic set_sample(input int v, input logic signed [15:0] s);
        voice_samples[16*v +: 16] = s;
    endtask

    task automatic wait_pulse(input string tag, input logic signed [15:0] exp, output int k);
        k = 0;
        while (!new_sample_ready && k < TO + 20) begin step(); k++; end
        check({tag, "_pulse"}, 32'(new_sample_ready), 32'(1));
        check(tag, 32'(sample_out), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1; play = 1'b0; beat = 1'b0; load_new_note = 1'b0;
        note = '0; duration = '0; generate_next_sample = 1'b0;
        voice_samples = '0; voice_sample_ready = '0;
        cyc = 0;
        model_reset();
        step(); step();
        check("rst_load", 32'(voice_load), 32'(0));
        check("rst_active", 32'(voice_active), 32'(0));
        check("rst_sample", 32'(sample_out), 32'(0));
        reset = 1'b0;
        step();

        // Fill the pool in index order.
        do_load(6'd10, 6'd4); check("fill_v0", 32'(voice_load), 32'(3'b001)); idle(4);
        do_load(6'd20, 6'd4); check("fill_v1", 32'(voice_load), 32'(3'b010)); idle(4);
        do_load(6'd30, 6'd4); check("fill_v2", 32'(voice_load), 32'(3'b100));
        check("fill_active", 32'(voice_active), 32'(3'b111));

        // Steal the voice with the fewest beats left: {3,1,2} -> voice 1.
        hard_reset();
        do_load(6'd5, 6'd3); do_load(6'd6, 6'd1); do_load(6'd7, 6'd2);
        do_load(6'd40, 6'd5);
        check("steal_load", 32'(voice_load), 32'(3'b010));
        check("steal_note", 32'(voice_note), 32'(40));
        play = 1'b1;
        beat = 1'b1; step(); step(); beat = 1'b0; step();
        check("steal_rem_a", 32'(voice_active), 32'(3'b011));
        beat = 1'b1; step(); beat = 1'b0; step();
        check("steal_rem_b", 32'(voice_active), 32'(3'b010));

        // Expiry with play high, freeze with play low.
        hard_reset();
        do_load(6'd9, 6'd2);
        play = 1'b1;
        beat = 1'b1; step(); beat = 1'b0;
        check("expire_mid", 32'(voice_active), 32'(3'b001));
        beat = 1'b1; step(); beat = 1'b0;
        check("expire_end", 32'(voice_active), 32'(3'b000));
        do_load(6'd9, 6'd2);
        play = 1'b0;
        beat = 1'b1; step(); step(); beat = 1'b0; step();
        check("frozen", 32'(voice_active), 32'(3'b001));

        // Beat coinciding with the load of the last free voice.
        do_load(6'd11, 6'd5);
        play = 1'b1; beat = 1'b1;
        do_load(6'd12, 6'd3);
        beat = 1'b0;
        check("beatload_sel", 32'(voice_load), 32'(3'b100));
        beat = 1'b1; step(); beat = 1'b0; step();
        check("beatload_active", 32'(voice_active), 32'(3'b110));

        // Positive and negative saturation.
        hard_reset();
        play = 1'b0;
        do_load(6'd10, 6'd40); do_load(6'd20, 6'd40);
        generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
        set_sample(0, 16'sd20000); set_sample(1, 16'sd20000); set_sample(2, 16'sd1000);
        voice_sample_ready = 3'b011; step(); voice_sample_ready = '0;
        wait_pulse("sat_pos", 16'sh7FFF, k);
        check("sat_pos_lat", 32'(k), 32'(1));
        step();
        check("single_pulse", 32'(new_sample_ready), 32'(0));
        step();
        generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
        set_sample(0, -16'sd20000); set_sample(1, -16'sd20000);
        voice_sample_ready = 3'b011; step(); voice_sample_ready = '0;
        wait_pulse("sat_neg", 16'sh8000, k);
        step(); step();

        // Voice 1 never answers: mix after the timeout with voice 0 alone.
        generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
        set_sample(0, 16'sd1234); set_sample(1, 16'sd7777);
        voice_sample_ready = 3'b001; step(); voice_sample_ready = '0;
        wait_pulse("timeout_val", 16'sd1234, k);
        check("timeout_lat", 32'(k), 32'(TO + 1));
        step(); step();

        // Nothing active: empty sum three cycles after the request.
        hard_reset();
        generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
        wait_pulse("empty_val", 16'sd0, k);
        check("empty_lat", 32'(k), 32'(2));
        step(); step();

        // Reset in the middle of a collection.
        do_load(6'd3, 6'd9);
        generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
        step();
        hard_reset();
        idle(5);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            load_new_note = ($urandom_range(0, 3) == 0);
            note = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            duration = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
            beat = ($urandom_range(0, 2) == 0);
            play = ($urandom_range(0, 4) != 0);
            generate_next_sample = ($urandom_range(0, 9) == 0);
            voice_sample_ready = NV'($urandom) & NV'($urandom);
            for (int i = 0; i < NV; i++) voice_samples[16*i +: 16] = 16'($urandom);
            step();
        end
        load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0; voice_sample_ready = '0;
        idle(TO + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
